led_pwm_fader: RTL and testbench
================================

Name: led_pwm_fader

Overview:
- Downstream stage for `blink`: consumes its per-LED on/off vector `led_out` and drives the physical LED pins.
- Each LED gets 8-bit PWM brightness that ramps smoothly toward a target, so hard blink edges become fades.
- Output polarity is configurable; the Tang Nano boards use active-low LEDs.
- Sits between `blink` and the top-level pin assignments.

Parameters:
- CLOCK_HZ, 27_000_000: system clock frequency in Hz.
- NUMBER_OF_LEDS, 3: number of LED channels.
- PWM_HZ, 1000: target PWM frame rate. PRESCALE = CLOCK_HZ/(PWM_HZ*256), integer floor, clamped to a minimum of 1.
- FADE_STEP, 1: brightness change per PWM frame (1..255).
- ACTIVE_LOW, 1: 1 means LED is lit when the pin is 0.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- led_in  input  NUMBER_OF_LEDS  on/off request per LED, from blink's led_out; same clock domain.
- max_level  input  8  brightness ceiling used when led_in[i]=1.
- led_out  output  NUMBER_OF_LEDS  PWM pin drive, polarity per ACTIVE_LOW.
- busy  output  1  1 while any channel level differs from its latched target.
- frame_start  output  1  one-cycle pulse at each PWM frame boundary.

Behaviour:
- Reset (asynchronous, takes effect immediately without a clock edge):
  - prescaler=0, pwm_count=0, all level[i]=0, all targets=0.
  - frame_start=0, busy=0.
  - led_out={NUMBER_OF_LEDS{ACTIVE_LOW}}, i.e. all LEDs off.
- Prescaler:
  - Counts 0..PRESCALE-1.
  - pwm_tick=1 on the cycle the prescaler equals PRESCALE-1; it then wraps to 0.
  - With PRESCALE=1, pwm_tick is asserted every cycle.
- pwm_count (8-bit):
  - Increments on pwm_tick and wraps 255→0.
  - Registered frame_start=1 for exactly one cycle after pwm_count wraps to 0.
  - Frame period = 256*PRESCALE cycles.
- Frame update, on the frame_start cycle, per channel:
  - target[i] = led_in[i] ? max_level : 0, sampled on that cycle only.
  - Changes to led_in or max_level mid-frame take effect at the next frame.
  - Ramp up, if level<target: level = min(level+FADE_STEP, target). Compute in 9 bits, so there is no wrap past 255.
  - Ramp down, if level>target: level = max(level-FADE_STEP, target). Compute signed/9-bit, so there is no underflow below 0.
  - If equal: level unchanged.
- PWM compare: on[i] = (pwm_count < level[i]).
  - level 0: never on.
  - level 255: on for 255 of 256 positions.
- Output register: led_out[i] <= on[i] ^ ACTIVE_LOW, one cycle after the compare inputs; fixed latency of 1 cycle.
- busy: registered; busy = OR over i of (level[i] != target[i]), evaluated after each frame update.
- Simultaneous events:
  - A frame update and a compare in the same cycle use the pre-update level.
  - The new level applies from the next pwm_count value onward, so a frame is never split between two levels.
- Reset mid-ramp: all ramp state is discarded; after release, ramping restarts from 0.
- led_in is not synchronized internally; it must come from the clock domain.

Decomposition:
- Package led_pwm_pkg:
  - localparam PWM_BITS=8.
  - typedef logic [PWM_BITS-1:0] level_t.
  - function calc_prescale(clock_hz, pwm_hz), returning max(1, floor).
- Sub-module led_fade_channel, one instance per LED via generate:
  - Inputs: clock, reset, frame_start, led_in bit, max_level, pwm_count.
  - Outputs: pin, busy bit.
  - Contains the target/level registers, saturating ramp and compare.
- Top level of this block holds the prescaler, pwm_count, frame_start and the busy OR.

Test Plan:
Bench parameters: CLOCK_HZ=2560, PWM_HZ=10 (PRESCALE=1, frame=256 cycles), NUMBER_OF_LEDS=3, ACTIVE_LOW=1.
- Reset asserted -> led_out=3'b111, busy=0, frame_start=0.
- Reset released, led_in=0 -> frame_start pulses every 256 cycles.
- led_in=3'b001, max_level=255, FADE_STEP=1:
  - In frame k (k=1..255), led_out[0]=0 for exactly k cycles.
  - Frame 10 -> 10 low cycles.
  - After 255 frames, busy=0.
  - led_out[2:1] stay 1 throughout.
- FADE_STEP=16, max_level=100, led_in=3'b010 -> ch1 levels 16,32,48,64,80,96,100 over 7 frames, then constant; busy drops after the 7th update.
- Ramp down: ch0 at level 255, then led_in[0] drops mid-frame ->
  - Current frame still 255 low cycles.
  - Subsequent frames 254, 253, …, reaching 0 with no underflow (FADE_STEP=16 -> …,15,0).
- reset asserted asynchronously mid-ramp -> led_out=3'b111 before the next clock edge; after release, the ramp restarts from level 0.
- max_level=0, led_in=3'b111 -> led_out remains 3'b111 indefinitely; busy stays 0.

Source files
------------

// File: rtl/led_pwm_pkg.sv
// ---------------------------------------------------------------------------
// led_pwm_pkg
// Shared definitions for the LED PWM fader: the PWM resolution, the
// brightness level type and the prescaler calculation used to derive the
// PWM tick rate from the system clock.
// ---------------------------------------------------------------------------
package led_pwm_pkg;

   localparam int PWM_BITS = 8;

   typedef logic [PWM_BITS-1:0] level_t;

   // Clock cycles per PWM step so that a full 256-step frame runs at roughly
   // pwm_hz. Integer floor, never below 1 so a slow clock still advances.
   function automatic int calc_prescale(input int clock_hz, input int pwm_hz);
      int p;
      p = clock_hz / (pwm_hz * (1 << PWM_BITS));
      return (p < 1) ? 1 : p;
   endfunction

endpackage

// File: rtl/led_fade_channel.sv
// ---------------------------------------------------------------------------
// led_fade_channel
// One LED channel: latches a brightness target at each frame boundary,
// ramps its level toward that target by FADE_STEP per frame with
// saturation, and drives the pin by comparing the shared PWM counter
// against the level.
//
// Ports:
//   clock, reset  system clock, asynchronous active-high reset
//   frame_start   one-cycle pulse marking the PWM frame boundary
//   led_in        on/off request for this LED
//   max_level     brightness used when led_in is 1
//   pwm_count     shared PWM position counter
//   pin           registered pin drive, polarity set by ACTIVE_LOW
//   busy          level has not yet reached the latched target
// ---------------------------------------------------------------------------
module led_fade_channel
   import led_pwm_pkg::*;
#(
   parameter int FADE_STEP  = 1,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic   clock,
   input  logic   reset,
   input  logic   frame_start,
   input  logic   led_in,
   input  level_t max_level,
   input  level_t pwm_count,
   output logic   pin,
   output logic   busy
);

   localparam logic [PWM_BITS:0]          STEP_UP   = (PWM_BITS+1)'(FADE_STEP);
   localparam logic signed [PWM_BITS+1:0] STEP_DOWN = (PWM_BITS+2)'(FADE_STEP);

   level_t                  level;
   level_t                  target;
   level_t                  target_next;
   level_t                  level_next;
   logic [PWM_BITS:0]       up_sum;
   logic signed [PWM_BITS+1:0] down_diff;

   // Saturating ramp toward the target sampled this cycle. The extra
   // headroom bits keep the sum from wrapping past 255 and the difference
   // from wrapping below 0 before the clamp is applied.
   always_comb begin
      target_next = led_in ? max_level : '0;
      up_sum      = {1'b0, level} + STEP_UP;
      down_diff   = $signed({2'b00, level}) - STEP_DOWN;
      level_next  = level;
      if (level < target_next) begin
         if (up_sum > {1'b0, target_next})
            level_next = target_next;
         else
            level_next = up_sum[PWM_BITS-1:0];
      end else if (level > target_next) begin
         if (down_diff < $signed({2'b00, target_next}))
            level_next = target_next;
         else
            level_next = down_diff[PWM_BITS-1:0];
      end
   end

   // Target and level only move on the frame boundary. The pin register
   // compares against the level held before this edge, so the cycle that
   // performs the update still shows the old level and the new level covers
   // a full 256-position frame from the next count onward.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         level  <= '0;
         target <= '0;
         pin    <= ACTIVE_LOW;
      end else begin
         if (frame_start) begin
            target <= target_next;
            level  <= level_next;
         end
         pin <= (pwm_count < level) ^ ACTIVE_LOW;
      end
   end

   assign busy = (level != target);

endmodule

// File: rtl/led_pwm_fader.sv
// ---------------------------------------------------------------------------
// led_pwm_fader
// Turns the hard on/off LED requests from blink into smooth PWM fades.
// Holds the shared PWM timebase (prescaler, 8-bit position counter and the
// frame boundary pulse) and one fade channel per LED.
//
// Ports:
//   clock, reset  system clock, asynchronous active-high reset
//   led_in        per-LED on/off request, same clock domain
//   max_level     brightness ceiling for lit LEDs
//   led_out       PWM pin drive, polarity per ACTIVE_LOW
//   busy          any channel still ramping toward its target
//   frame_start   one-cycle pulse at each PWM frame boundary
// ---------------------------------------------------------------------------
module led_pwm_fader
   import led_pwm_pkg::*;
#(
   parameter int CLOCK_HZ       = 27_000_000,
   parameter int NUMBER_OF_LEDS = 3,
   parameter int PWM_HZ         = 1000,
   parameter int FADE_STEP      = 1,
   parameter bit ACTIVE_LOW     = 1'b1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUMBER_OF_LEDS-1:0] led_in,
   input  level_t                    max_level,
   output logic [NUMBER_OF_LEDS-1:0] led_out,
   output logic                      busy,
   output logic                      frame_start
);

   localparam int PRESCALE   = calc_prescale(CLOCK_HZ, PWM_HZ);
   localparam int PRESCALE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PRESCALE_W-1:0]     prescaler;
   logic                      pwm_tick;
   level_t                    pwm_count;
   logic [NUMBER_OF_LEDS-1:0] chan_busy;

   assign pwm_tick = (prescaler == PRESCALE_W'(PRESCALE - 1));

   // Timebase: the prescaler divides the clock down to PWM steps, the
   // position counter wraps every 256 steps, and frame_start is raised for
   // the single cycle right after the counter wraps to 0.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prescaler   <= '0;
         pwm_count   <= '0;
         frame_start <= 1'b0;
      end else begin
         prescaler   <= pwm_tick ? '0 : prescaler + PRESCALE_W'(1);
         if (pwm_tick)
            pwm_count <= pwm_count + level_t'(1);
         frame_start <= pwm_tick && (pwm_count == '1);
      end
   end

   // Registered summary of all channels that have not reached their target.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         busy <= 1'b0;
      else
         busy <= |chan_busy;
   end

   for (genvar i = 0; i < NUMBER_OF_LEDS; i++) begin : g_channel
      led_fade_channel #(
         .FADE_STEP  (FADE_STEP),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_channel (
         .clock       (clock),
         .reset       (reset),
         .frame_start (frame_start),
         .led_in      (led_in[i]),
         .max_level   (max_level),
         .pwm_count   (pwm_count),
         .pin         (led_out[i]),
         .busy        (chan_busy[i])
      );
   end

endmodule

// File: tb/tb_led_pwm_fader.sv
// ---------------------------------------------------------------------------
// tb_led_pwm_fader
// Drives two faders (FADE_STEP 1 and 16) with the same inputs and checks
// them against a frame-level brightness model: each frame the model moves
// every channel's level toward its target, and the bench counts how many
// cycles each pin is lit per 256-cycle window.
// ---------------------------------------------------------------------------
module tb_led_pwm_fader;

   localparam int FRAME = 256;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] led_in = 3'b000;
   logic [7:0] max_level = 8'd0;

   logic [2:0] led_out_s1;
   logic [2:0] led_out_s16;
   logic       busy_s1;
   logic       busy_s16;
   logic       frame_start_s1;
   logic       frame_start_s16;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   int step_size [2] = '{1, 16};
   int lvl    [2][3];
   int tgt    [2][3];
   int lowcnt [2][3];

   always #5 clock = ~clock;

   led_pwm_fader #(
      .CLOCK_HZ       (2560),
      .NUMBER_OF_LEDS (3),
      .PWM_HZ         (10),
      .FADE_STEP      (1),
      .ACTIVE_LOW     (1'b1)
   ) dut_s1 (
      .clock       (clock),
      .reset       (reset),
      .led_in      (led_in),
      .max_level   (max_level),
      .led_out     (led_out_s1),
      .busy        (busy_s1),
      .frame_start (frame_start_s1)
   );

   led_pwm_fader #(
      .CLOCK_HZ       (2560),
      .NUMBER_OF_LEDS (3),
      .PWM_HZ         (10),
      .FADE_STEP      (16),
      .ACTIVE_LOW     (1'b1)
   ) dut_s16 (
      .clock       (clock),
      .reset       (reset),
      .led_in      (led_in),
      .max_level   (max_level),
      .led_out     (led_out_s16),
      .busy        (busy_s16),
      .frame_start (frame_start_s16)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Model state after reset: everything dark, cycle count restarts.
   task automatic modelReset();
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < 3; c++) begin
            lvl[d][c]    = 0;
            tgt[d][c]    = 0;
            lowcnt[d][c] = 0;
         end
      cyc = 0;
   endtask

   // Advances one clock and checks the result. Cycle n counts edges since
   // reset release; frame boundaries are seen at n = 256k, the level update
   // happens on edge 256k+1, and the pins reflect that level for the window
   // of cycles 256k+2 .. 256k+257.
   task automatic stepCycle();
      logic [2:0] in_snap;
      int         max_snap;
      logic [2:0] outs [2];
      logic       fss  [2];
      logic       bsys [2];
      int         ph;
      int         t;
      int         any_busy;
      in_snap  = led_in;
      max_snap = int'(max_level);
      @(posedge clock);
      #1;
      cyc++;
      outs[0] = led_out_s1;  outs[1] = led_out_s16;
      fss[0]  = frame_start_s1; fss[1] = frame_start_s16;
      bsys[0] = busy_s1;     bsys[1] = busy_s16;
      if (cyc >= 2) begin
         ph = (cyc - 2) % FRAME;
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < 3; c++) begin
               if (ph == 0) lowcnt[d][c] = 0;
               if (outs[d][c] == 1'b0) lowcnt[d][c]++;
               if (ph == FRAME - 1)
                  checkOutput($sformatf("lit_cycles step%0d ch%0d frame%0d",
                                        step_size[d], c, (cyc - 2) / FRAME),
                              lowcnt[d][c], lvl[d][c]);
            end
      end
      for (int d = 0; d < 2; d++)
         checkOutput($sformatf("frame_start step%0d", step_size[d]),
                     fss[d], (cyc % FRAME == 0) ? 1 : 0);
      if (cyc % FRAME == 1 && cyc > 1) begin
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < 3; c++) begin
               t = in_snap[c] ? max_snap : 0;
               tgt[d][c] = t;
               if (lvl[d][c] + step_size[d] <= t)
                  lvl[d][c] = lvl[d][c] + step_size[d];
               else if (lvl[d][c] < t)
                  lvl[d][c] = t;
               else if (lvl[d][c] - step_size[d] >= t)
                  lvl[d][c] = lvl[d][c] - step_size[d];
               else
                  lvl[d][c] = t;
            end
      end
      if (cyc % FRAME == FRAME / 2) begin
         for (int d = 0; d < 2; d++) begin
            any_busy = 0;
            for (int c = 0; c < 3; c++)
               if (lvl[d][c] != tgt[d][c]) any_busy = 1;
            checkOutput($sformatf("busy step%0d", step_size[d]), bsys[d], any_busy);
         end
      end
   endtask

   task automatic runCycles(input int n);
      repeat (n) stepCycle();
   endtask

   // Asserts reset in the middle of a clock-high phase and checks that the
   // outputs clear with no clock edge, then releases on a falling edge.
   task automatic applyStimulus_reset(input string tag);
      #3;
      reset = 1'b1;
      #1;
      checkOutput({tag, " led_out step1"},     led_out_s1,      3'b111);
      checkOutput({tag, " led_out step16"},    led_out_s16,     3'b111);
      checkOutput({tag, " busy step1"},        busy_s1,         1'b0);
      checkOutput({tag, " busy step16"},       busy_s16,        1'b0);
      checkOutput({tag, " frame_start step1"}, frame_start_s1,  1'b0);
      checkOutput({tag, " frame_start step16"},frame_start_s16, 1'b0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      modelReset();
   endtask

   initial begin
      $display("[TB] led_pwm_fader bench start");
      modelReset();

      // Power-up reset before the first clock edge.
      #1;
      reset = 1'b1;
      #2;
      checkOutput("reset led_out step1",     led_out_s1,      3'b111);
      checkOutput("reset led_out step16",    led_out_s16,     3'b111);
      checkOutput("reset busy step1",        busy_s1,         1'b0);
      checkOutput("reset busy step16",       busy_s16,        1'b0);
      checkOutput("reset frame_start step1", frame_start_s1,  1'b0);
      checkOutput("reset frame_start step16",frame_start_s16, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      modelReset();

      // Idle frames, then LED 0 requested at full brightness mid-frame.
      runCycles(2 * FRAME + $urandom_range(20, 200));
      led_in    = 3'b001;
      max_level = 8'd255;
      runCycles(257 * FRAME);
      checkOutput("ramp up done busy step1",  busy_s1,  1'b0);
      checkOutput("ramp up done busy step16", busy_s16, 1'b0);

      // LED 0 released mid-frame, LED 1 fades to 100.
      runCycles($urandom_range(20, 200));
      led_in    = 3'b010;
      max_level = 8'd100;
      runCycles(18 * FRAME);

      // Reset in the middle of a ramp, then the ramp restarts from zero.
      led_in    = 3'b111;
      max_level = 8'($urandom_range(150, 255));
      runCycles(3 * FRAME + $urandom_range(10, 200));
      applyStimulus_reset("mid-ramp reset");
      runCycles(4 * FRAME);

      // Zero ceiling: all LEDs stay dark and nothing is ever busy.
      max_level = 8'd0;
      applyStimulus_reset("zero ceiling reset");
      for (int i = 0; i < 2 * FRAME + 8; i++) begin
         stepCycle();
         checkOutput("zero ceiling led_out step1",  led_out_s1,  3'b111);
         checkOutput("zero ceiling led_out step16", led_out_s16, 3'b111);
         checkOutput("zero ceiling busy step1",     busy_s1,     1'b0);
      end

      // Random requests and ceilings changing at random points in a frame.
      for (int s = 0; s < 6; s++) begin
         led_in    = 3'($urandom_range(0, 7));
         max_level = 8'($urandom_range(0, 255));
         runCycles($urandom_range(FRAME, 3 * FRAME));
      end
      runCycles(2 * FRAME);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
